// File: rtl/imem_multiport.sv
// imem_multiport: shared instruction word array serving NUM_PORTS independent
// fetch channels, each with a one-cycle registered response that can be held
// under stall, plus a byte-enabled write port for run-time program patching.
//
// Per-channel handshake: fetch_req issues a fetch whenever the channel is not
// holding a response; the response appears one cycle later with fetch_valid=1.
// While fetch_valid=1 and fetch_stall=1, the response is frozen and any request
// presented in that cycle is ignored (not queued); the requester must re-present it.
module imem_multiport #(
    parameter int          IMEM_BYTES = 4096,
    parameter int          NUM_PORTS  = 2,
    parameter string       INIT_FILE  = "",
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PORTS-1:0]    fetch_req,
    input  logic [NUM_PORTS*32-1:0] fetch_pc,
    input  logic [NUM_PORTS-1:0]    fetch_stall,
    output logic [NUM_PORTS-1:0]    fetch_valid,
    output logic [NUM_PORTS*32-1:0] fetch_instr,
    output logic [NUM_PORTS-1:0]    fetch_fault,
    input  logic                    wr_en,
    input  logic [31:0]             wr_addr,
    input  logic [31:0]             wr_data,
    input  logic [3:0]              wr_be
);

    localparam int          WORDS     = IMEM_BYTES / 4;
    localparam int          AW        = $clog2(WORDS);
    localparam logic [31:0] MEM_LIMIT = 32'(IMEM_BYTES);

    // Shared word array; contents survive reset.
    logic [31:0] mem [WORDS];

    // Write qualification: addresses past the end are dropped, not aliased.
    logic          wr_hit;
    logic [AW-1:0] wr_idx;

    always_comb begin
        wr_hit = wr_en && (wr_addr < MEM_LIMIT);
        wr_idx = wr_addr[AW+1:2];
    end

    // Byte-lane write; non-blocking so same-edge reads see the old word.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) begin
                    mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_PORTS; i++) begin : g_port
            logic [31:0]   pc;
            logic [AW-1:0] rd_idx;
            logic          hold;
            logic          issue;
            logic          bad_pc;
            logic          load_d;
            logic          valid_d;
            logic          valid_q;
            logic          fault_d;
            logic          fault_q;
            logic [31:0]   instr_q;

            // Channel control: hold beats issue beats idle.
            always_comb begin
                pc      = fetch_pc[32*i +: 32];
                rd_idx  = pc[AW+1:2];
                hold    = valid_q && fetch_stall[i];
                issue   = fetch_req[i] && !hold;
                bad_pc  = (pc[1:0] != 2'b00) || (pc >= MEM_LIMIT);
                valid_d = valid_q;
                fault_d = fault_q;
                load_d  = 1'b0;
                if (hold) begin
                    valid_d = valid_q;
                    fault_d = fault_q;
                end else if (issue) begin
                    valid_d = 1'b1;
                    fault_d = bad_pc;
                    load_d  = !bad_pc;
                end else begin
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                end
            end

            // Response status flops.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    fault_q <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                    fault_q <= fault_d;
                end
            end

            // Registered read port; the array is indexed directly here (not via
            // a combinational _d) so the read maps onto a RAM output register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    instr_q <= NOP_INSTR;
                end else if (load_d) begin
                    instr_q <= mem[rd_idx];
                end else if (issue) begin
                    instr_q <= NOP_INSTR;
                end
            end

            assign fetch_valid[i]         = valid_q;
            assign fetch_fault[i]         = fault_q;
            assign fetch_instr[32*i +: 32] = instr_q;
        end
    endgenerate

endmodule

// File: tb/tb_imem_multiport.sv
// tb_imem_multiport: directed scenarios plus random traffic against a
// behavioural model of the fetch/write rules, checked through per-channel
// expected queues popped by an independent monitor.
module tb_imem_multiport;

    localparam int          NP    = 2;
    localparam int          BYTES = 4096;
    localparam int          WORDS = BYTES / 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    fetch_req = '0;
    logic [NP*32-1:0] fetch_pc = '0;
    logic [NP-1:0]    fetch_stall = '0;
    logic [NP-1:0]    fetch_valid;
    logic [NP*32-1:0] fetch_instr;
    logic [NP-1:0]    fetch_fault;
    logic             wr_en = 1'b0;
    logic [31:0]      wr_addr = '0;
    logic [31:0]      wr_data = '0;
    logic [3:0]       wr_be = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {valid, fault, instr} per channel per cycle.
    logic [33:0] exp_q0[$];
    logic [33:0] exp_q1[$];

    // Reference model state.
    logic [31:0] m_mem [WORDS];
    logic        m_valid [NP];
    logic        m_fault [NP];
    logic [31:0] m_instr [NP];
    logic [31:0] m_pc;

    imem_multiport #(
        .IMEM_BYTES (BYTES),
        .NUM_PORTS  (NP),
        .INIT_FILE  (""),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_stall (fetch_stall),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(string name, logic [33:0] act, logic [33:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got v=%b f=%b instr=%h, expected v=%b f=%b instr=%h",
                     name, act[33], act[32], act[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    task automatic expect_ch(int ch, logic v, logic f, logic [31:0] ins, string name);
        check(name, {fetch_valid[ch], fetch_fault[ch], fetch_instr[32*ch +: 32]}, {v, f, ins});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(int ch, logic [31:0] pc);
        fetch_pc[32*ch +: 32] = pc;
    endtask

    task automatic write_word(logic [31:0] addr, logic [31:0] data, logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wr_be   = be;
        cyc();
        wr_en = 1'b0;
    endtask

    // Reference model: applies the fetch rules to the inputs seen at each edge,
    // then the write (reads see the pre-write array).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) begin
                m_valid[i] = 1'b0;
                m_fault[i] = 1'b0;
                m_instr[i] = NOP;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                m_pc = fetch_pc[32*i +: 32];
                if (m_valid[i] && fetch_stall[i]) begin
                    m_valid[i] = 1'b1;
                end else if (fetch_req[i]) begin
                    m_valid[i] = 1'b1;
                    if ((m_pc % 4) != 0 || m_pc >= BYTES) begin
                        m_fault[i] = 1'b1;
                        m_instr[i] = NOP;
                    end else begin
                        m_fault[i] = 1'b0;
                        m_instr[i] = m_mem[m_pc / 4];
                    end
                end else begin
                    m_valid[i] = 1'b0;
                    m_fault[i] = 1'b0;
                end
                if (i == 0) exp_q0.push_back({m_valid[i], m_fault[i], m_instr[i]});
                else        exp_q1.push_back({m_valid[i], m_fault[i], m_instr[i]});
            end
            if (wr_en && wr_addr < BYTES) begin
                for (int k = 0; k < 4; k++) begin
                    if (wr_be[k]) m_mem[wr_addr / 4][8*k +: 8] = wr_data[8*k +: 8];
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the queued expectations.
    always @(negedge clk) begin
        logic [33:0] exp;
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) begin
                check($sformatf("reset_ch%0d", i),
                      {fetch_valid[i], fetch_fault[i], fetch_instr[32*i +: 32]}, {2'b00, NOP});
            end
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            for (int i = 0; i < NP; i++) begin
                if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_empty_ch%0d: got output with no expectation queued", i);
                end else begin
                    exp = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check($sformatf("sb_ch%0d", i),
                          {fetch_valid[i], fetch_fault[i], fetch_instr[32*i +: 32]}, exp);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [31:0] pc;
        int          r;

        // Reset with requests pending on both channels.
        rst_n     = 1'b0;
        fetch_req = 2'b11;
        set_pc(0, 32'h0);
        set_pc(1, 32'h0);
        repeat (3) cyc();
        expect_ch(0, 1'b0, 1'b0, NOP, "reset_hold_ch0");
        expect_ch(1, 1'b0, 1'b0, NOP, "reset_hold_ch1");
        fetch_req = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Preload the whole array, then the known program words.
        for (int w = 0; w < WORDS; w++) write_word(w * 4, $urandom, 4'hF);
        write_word(32'h00, 32'h0010_0313, 4'hF);
        write_word(32'h04, 32'h0020_0393, 4'hF);
        write_word(32'h08, 32'h0053_0433, 4'hF);
        write_word(32'h0C, 32'h0063_84B3, 4'hF);
        write_word(32'h10, 32'hFFFF_FFFF, 4'hF);

        // Back-to-back fetches on channel 0.
        fetch_req = 2'b01;
        set_pc(0, 32'h0); cyc(); expect_ch(0, 1'b1, 1'b0, 32'h0010_0313, "fetch_w0");
        set_pc(0, 32'h4); cyc(); expect_ch(0, 1'b1, 1'b0, 32'h0020_0393, "fetch_w1");
        set_pc(0, 32'h8); cyc(); expect_ch(0, 1'b1, 1'b0, 32'h0053_0433, "fetch_w2");
        set_pc(0, 32'hC); cyc(); expect_ch(0, 1'b1, 1'b0, 32'h0063_84B3, "fetch_w3");
        fetch_req = 2'b00; cyc();
        expect_ch(0, 1'b0, 1'b0, 32'h0063_84B3, "idle_keeps_instr");

        // Both channels read the same word, then channel 1 stalls.
        fetch_req = 2'b11;
        set_pc(0, 32'h8);
        set_pc(1, 32'h8);
        cyc();
        expect_ch(0, 1'b1, 1'b0, 32'h0053_0433, "dual_ch0");
        expect_ch(1, 1'b1, 1'b0, 32'h0053_0433, "dual_ch1");
        fetch_req   = 2'b11;
        fetch_stall = 2'b10;
        set_pc(0, 32'hC);
        set_pc(1, 32'h0);
        repeat (3) begin
            cyc();
            expect_ch(1, 1'b1, 1'b0, 32'h0053_0433, "stall_hold_ch1");
            expect_ch(0, 1'b1, 1'b0, 32'h0063_84B3, "nostall_ch0");
        end
        fetch_stall = 2'b00;
        fetch_req   = 2'b00;
        cyc();

        // Stall while idle has no effect on a new request.
        fetch_stall = 2'b01;
        fetch_req   = 2'b01;
        set_pc(0, 32'h4);
        cyc();
        expect_ch(0, 1'b1, 1'b0, 32'h0020_0393, "stall_idle_issue");
        fetch_stall = 2'b00;

        // Faults.
        set_pc(0, 32'h6);    cyc(); expect_ch(0, 1'b1, 1'b1, NOP, "fault_misaligned");
        set_pc(0, 32'h1000); cyc(); expect_ch(0, 1'b1, 1'b1, NOP, "fault_range");
        set_pc(0, 32'h0);    cyc(); expect_ch(0, 1'b1, 1'b0, 32'h0010_0313, "fault_clear");

        // Partial write with a same-edge fetch (read-first), then a later fetch.
        set_pc(0, 32'h10);
        write_word(32'h10, 32'hDEAD_BEEF, 4'b0011);
        expect_ch(0, 1'b1, 1'b0, 32'hFFFF_FFFF, "wr_collision_old");
        cyc();
        expect_ch(0, 1'b1, 1'b0, 32'hFFFF_BEEF, "wr_partial_new");
        write_word(32'h10, 32'h1234_5678, 4'b0000);
        cyc();
        expect_ch(0, 1'b1, 1'b0, 32'hFFFF_BEEF, "wr_be_zero");
        write_word(32'h1000, 32'h0, 4'hF);
        set_pc(0, 32'h0);
        cyc();
        expect_ch(0, 1'b1, 1'b0, 32'h0010_0313, "wr_out_of_range");

        // A held response ignores a later write to its word.
        fetch_req = 2'b10;
        set_pc(1, 32'h0);
        cyc();
        fetch_stall = 2'b10;
        fetch_req   = 2'b00;
        write_word(32'h0, 32'hCAFE_F00D, 4'hF);
        cyc();
        expect_ch(1, 1'b1, 1'b0, 32'h0010_0313, "hold_vs_write");
        fetch_stall = 2'b00;
        fetch_req   = 2'b10;
        cyc();
        expect_ch(1, 1'b1, 1'b0, 32'hCAFE_F00D, "after_hold_write");
        fetch_req = 2'b00;
        cyc();

        // Reset asserted between edges while channel 0 holds a response.
        fetch_req = 2'b01;
        set_pc(0, 32'h8);
        cyc();
        fetch_stall = 2'b01;
        fetch_req   = 2'b00;
        cyc();
        expect_ch(0, 1'b1, 1'b0, 32'h0053_0433, "pre_reset_hold");
        #2 rst_n = 1'b0;
        #1 expect_ch(0, 1'b0, 1'b0, NOP, "async_reset_drop");
        fetch_stall = 2'b00;
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < NP; ch++) begin
                r = $urandom_range(0, 9);
                if (r <= 6)      pc = 32'($urandom_range(0, 31)) * 4;
                else if (r == 7) pc = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
                else if (r == 8) pc = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
                else             pc = $urandom;
                set_pc(ch, pc);
                fetch_req[ch]   = ($urandom_range(0, 3) != 0);
                fetch_stall[ch] = ($urandom_range(0, 3) == 0);
            end
            wr_en = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) wr_addr = 32'h1000 + 32'($urandom_range(0, 31)) * 4;
            else                           wr_addr = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            cyc();
        end
        wr_en       = 1'b0;
        fetch_req   = '0;
        fetch_stall = '0;
        repeat (2) cyc();
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
